// File: rtl/matriz_pkg.sv
// matriz_pkg: shared constants, FSM states and element indexing for the 5x5 int8 matrix path.
package matriz_pkg;
    localparam int N = 5;
    localparam int W = 8;
    localparam int ELEMS = N * N;
    localparam int MAT_BITS = ELEMS * W;
    typedef enum logic [1:0] {IDLE, RUN, CAPT, DRAIN} state_t;
    function automatic int idx(input int r, input int c);
        return W * (c + N * r);
    endfunction
endpackage

// File: rtl/serializa_resultado.sv
// serializa_resultado: holds the captured product and streams it out one element per handshake.
module serializa_resultado import matriz_pkg::*; #(
    parameter int N = matriz_pkg::N,
    parameter int W = matriz_pkg::W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_capt,
    input  logic             i_drain,
    input  logic [N*N*W-1:0] i_result,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic             o_last,
    output logic             o_done
);
    localparam int E = N * N;
    localparam int KW = $clog2(E);
    localparam logic [KW-1:0] K_LAST = KW'(E - 1);

    logic [E*W-1:0] r_buf;
    logic [KW-1:0]  r_k;

    assign o_valid = i_drain;
    assign o_last  = i_drain && r_k == K_LAST;
    assign o_data  = i_drain ? r_buf[r_k*W +: W] : '0;
    assign o_done  = o_last && i_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_buf <= '0;
            r_k   <= '0;
        end else if (i_capt) begin
            r_buf <= i_result;
            r_k   <= '0;
        end else if (i_drain && i_ready) begin
            r_k   <= o_last ? '0 : r_k + KW'(1);
        end
endmodule

// File: rtl/carrega_matriz.sv
// carrega_matriz: loads operands A/B from a byte stream, runs the multiplier for one
// five-row pass, captures the product and streams it back out.
module carrega_matriz import matriz_pkg::*; #(
    parameter int N = matriz_pkg::N,
    parameter int W = matriz_pkg::W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [W-1:0]     in_data,
    input  logic             cmd_go,
    output logic             cmd_err,
    output logic             busy,
    output logic [N*N*W-1:0] mat_a,
    output logic [N*N*W-1:0] mat_b,
    output logic             mult_start,
    input  logic [N*N*W-1:0] mult_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             res_last
);
    localparam int E = N * N;
    localparam int CW = $clog2(E + 1);
    localparam logic [CW-1:0] FULL = CW'(E);
    localparam logic [2:0] RUN_LAST = 3'(N - 1);

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt_a, r_cnt_b, w_cnt_sel;
    logic [2:0]     r_run;
    logic [E*W-1:0] r_mat_a, r_mat_b;
    logic           r_cmd_err, w_beat, w_full, w_go, w_done;

    assign w_cnt_sel  = in_sel ? r_cnt_b : r_cnt_a;
    assign in_ready   = r_state == IDLE && w_cnt_sel < FULL;
    assign w_beat     = in_valid && in_ready;
    // go sees the counters before any beat landing in the same cycle
    assign w_full     = r_cnt_a == FULL && r_cnt_b == FULL;
    assign w_go       = r_state == IDLE && cmd_go && w_full;
    assign busy       = r_state != IDLE;
    assign mult_start = r_state == RUN;
    assign cmd_err    = r_cmd_err;
    assign mat_a      = r_mat_a;
    assign mat_b      = r_mat_b;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? RUN : IDLE;
            RUN:     w_next = r_run == RUN_LAST ? CAPT : RUN;
            CAPT:    w_next = DRAIN;
            DRAIN:   w_next = w_done ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state   <= IDLE;
            r_run     <= '0;
            r_cmd_err <= 1'b0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_mat_a   <= '0;
            r_mat_b   <= '0;
        end else begin
            r_state   <= w_next;
            r_run     <= r_state == RUN ? r_run + 3'd1 : 3'd0;
            r_cmd_err <= r_state == IDLE && cmd_go && !w_full;
            if (w_beat && !in_sel) begin
                r_mat_a[w_cnt_sel*W +: W] <= in_data;
                r_cnt_a <= r_cnt_a + CW'(1);
            end
            if (w_beat && in_sel) begin
                r_mat_b[w_cnt_sel*W +: W] <= in_data;
                r_cnt_b <= r_cnt_b + CW'(1);
            end
            // operands stay in place but must be reloaded before the next go
            if (w_done) begin
                r_cnt_a <= '0;
                r_cnt_b <= '0;
            end
        end

    serializa_resultado #(.N(N), .W(W)) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_capt   (r_state == CAPT),
        .i_drain  (r_state == DRAIN),
        .i_result (mult_result),
        .i_ready  (res_ready),
        .o_valid  (res_valid),
        .o_data   (res_data),
        .o_last   (res_last),
        .o_done   (w_done)
    );
endmodule

// File: doc/carrega_matriz.md
# carrega_matriz

Front-end and sequencer for the 5×5 signed-8-bit matrix multiplier.
- Accepts matrix elements as a valid/ready byte stream and assembles operands A and B in row-major order.
- On command, drives the multiplier's start line for exactly one full pass of five rows, then captures the 200-bit result.
- Streams the result back out byte by byte.
- Sits between the host/bus interface and the multiplier, which receives `mat_a`, `mat_b` and `mult_start` and returns `mult_result`.

## Interface
Parameters:
- `N`, 5, matrix dimension
- `W`, 8, element width in bits

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  element beat valid
- `in_ready`  out  1  element beat accepted when high with `in_valid`
- `in_sel`  in  1  target operand: 0 = A, 1 = B
- `in_data`  in  W  element value, two's complement
- `cmd_go`  in  1  single-cycle request to start a multiplication
- `cmd_err`  out  1  one-cycle pulse: `cmd_go` rejected
- `busy`  out  1  high outside IDLE
- `mat_a`  out  N·N·W  operand A to the multiplier; element (r,c) at bits [8(c+5r) +: 8]
- `mat_b`  out  N·N·W  operand B, same layout
- `mult_start`  out  1  multiplier enable, one row per cycle
- `mult_result`  in  N·N·W  multiplier product, same layout
- `res_valid`  out  1  result byte valid
- `res_ready`  in  1  result byte consumed
- `res_data`  out  W  result element
- `res_last`  out  1  high with element 24

## Operation
- States:
  - IDLE: load
  - RUN: 5 cycles
  - CAPT: 1 cycle
  - DRAIN: stream results
  - Return to IDLE after DRAIN.
- Operand counters `cnt_a`, `cnt_b` (0..25, 5 bits), one per operand.
- Load beat (IDLE, `in_valid && in_ready`): writes `in_data` to element index `cnt[in_sel]` of the selected operand, then increments that counter.
- `in_ready` is combinational: `state==IDLE && cnt[in_sel] < 25`. A full operand back-pressures only beats targeting that operand.
- `cmd_go` in IDLE:
  - Accepted only if `cnt_a==25 && cnt_b==25`, evaluated on pre-beat values when a load beat occurs in the same cycle. Accepted → RUN.
  - Otherwise `cmd_err` pulses next cycle and the state stays IDLE.
- `cmd_go` outside IDLE: ignored, no error.
- RUN: `mult_start` high for exactly 5 consecutive cycles, counted by a 3-bit run counter. `done_multiplicacao` is not used for sequencing.
- CAPT: registers `mult_result` into the internal result buffer.
- DRAIN:
  - Presents element k (0..24) row-major; advances on `res_valid && res_ready`.
  - `res_last` is high for k = 24.
  - After the last handshake: state goes to IDLE and `cnt_a`, `cnt_b` clear to 0.
  - `mat_a` and `mat_b` contents are retained, but both operands must be reloaded before the next `cmd_go`.
- Arithmetic: none. Product wrap to 8 bits is the multiplier's behaviour; bytes pass through unchanged.

## Timing
- Reset values:
  - state IDLE; counters 0
  - `mat_a`, `mat_b`, result buffer 0
  - `mult_start`, `busy`, `cmd_err`, `res_valid`, `res_last` 0
  - `res_data` 0
  - `in_ready` 1
- `cmd_go` accepted at edge t:
  - `busy` and `mult_start` high in cycles t+1..t+5
  - CAPT in cycle t+6
  - first `res_valid` in cycle t+7
- Minimum go→last-result latency is 31 cycles with `res_ready` tied high.
- `mat_a` and `mat_b` are stable from go through CAPT, since no loads are accepted outside IDLE.
- `res_data` and `res_last` hold while `res_valid && !res_ready`.
- Reset asserted mid-RUN or mid-DRAIN:
  - All outputs drop immediately (asynchronous).
  - The partial result is discarded.
  - The multiplier has no reset; the system integrator guarantees it is reset alongside this block.

## Structure
- Package `matriz_pkg`:
  - `N`, `W`, `ELEMS = 25`, `MAT_BITS = 200`
  - state enum {IDLE, RUN, CAPT, DRAIN}
  - index function (r,c) → 8(c+5r)
- Sub-module `serializa_resultado`: result buffer, CAPT load, DRAIN element counter, valid/ready/last generation.
- Top-level: operand loading, counters, FSM.

## Test plan
- Load A = identity, B elements 1..25, `cmd_go` → `mult_start` high exactly 5 cycles; bytes 1..25 in order; `res_last` on the 25th.
- `cmd_go` with `cnt_a`=25, `cnt_b`=24 → `cmd_err` pulses once; `busy` stays 0; 25th B beat then `cmd_go` → accepted.
- 26th beat to A while B is loading → `in_ready` low for `in_sel`=0, high for `in_sel`=1; A unchanged.
- Random `res_ready` back-pressure during DRAIN → no byte dropped or duplicated; `res_data` stable while stalled.
- `rst_n` low during RUN cycle 3 → `mult_start` 0 same cycle; after release `cnt_a`=`cnt_b`=0, `in_ready`=1, `mat_a`=0.
- Load beat and `cmd_go` in the same cycle, with the beat being B element 25 → go rejected (pre-beat count 24); next-cycle `cmd_go` accepted.
